// File: rtl/link_pkt_sched.sv
// Packet sequencer: latches RX packets for byte-wise SPI readout and
// collects TX bytes from SPI for MSB-first serialization on sh_en.
module link_pkt_sched #(
  parameter int unsigned PKT_BYTES   = 8,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx_mode,
  input  logic                          pkt_rec,
  input  logic [8*PKT_BYTES-1:0]        shift_data,
  input  logic                          cs,
  input  logic [7:0]                    spi_rx_byte,
  input  logic                          sh_en,
  output logic [7:0]                    spi_tx_byte,
  output logic                          pkt_ld,
  output logic                          shift_rst,
  output logic                          irq,
  output logic                          tx_bit,
  output logic                          tx_active,
  output logic [$clog2(PKT_BYTES)-1:0]  byte_idx,
  output logic                          overrun,
  output logic                          timeout
);

  localparam int unsigned PKT_W = 8 * PKT_BYTES;
  localparam int unsigned IDX_W = $clog2(PKT_BYTES);
  localparam int unsigned BIT_W = $clog2(PKT_W);
  localparam int unsigned TMO_W = 16;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RX_WAIT    = 3'd1,
    S_RX_READ    = 3'd2,
    S_TX_COLLECT = 3'd3,
    S_TX_SEND    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               cs_s1_q, cs_s2_q, cs_s3_q;
  logic               pkt_rec_q;
  logic [PKT_W-1:0]   pkt_q, pkt_d;
  logic [PKT_W-1:0]   tx_q, tx_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [7:0]         spi_tx_byte_q, spi_tx_byte_d;
  logic               pkt_ld_q, pkt_ld_d;
  logic               shift_rst_q, shift_rst_d;
  logic               irq_q, irq_d;
  logic               tx_bit_q, tx_bit_d;
  logic               tx_active_q, tx_active_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;

  logic               cs_rise_c, cs_fall_c, cs_edge_c;
  logic               pkt_rise_c, last_byte_c, last_bit_c, tmo_hit_c;
  logic [BIT_W-1:0]   tx_sel_c;

  // Edges are taken on the synchronized chip select only.
  assign cs_rise_c   = cs_s2_q & ~cs_s3_q;
  assign cs_fall_c   = ~cs_s2_q & cs_s3_q;
  assign cs_edge_c   = cs_rise_c | cs_fall_c;
  assign pkt_rise_c  = pkt_rec & ~pkt_rec_q;
  assign last_byte_c = (byte_idx_q == IDX_W'(PKT_BYTES - 1));
  assign last_bit_c  = (bit_cnt_q == BIT_W'(PKT_W - 1));
  assign tmo_hit_c   = (state_q == S_RX_READ) && !cs_edge_c &&
                       (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));

  // State register plus all datapath/output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cs_s1_q       <= 1'b1;
      cs_s2_q       <= 1'b1;
      cs_s3_q       <= 1'b1;
      pkt_rec_q     <= 1'b0;
      pkt_q         <= '0;
      tx_q          <= '0;
      byte_idx_q    <= '0;
      bit_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      spi_tx_byte_q <= '0;
      pkt_ld_q      <= 1'b0;
      shift_rst_q   <= 1'b0;
      irq_q         <= 1'b0;
      tx_bit_q      <= 1'b0;
      tx_active_q   <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cs_s1_q       <= cs;
      cs_s2_q       <= cs_s1_q;
      cs_s3_q       <= cs_s2_q;
      pkt_rec_q     <= pkt_rec;
      pkt_q         <= pkt_d;
      tx_q          <= tx_d;
      byte_idx_q    <= byte_idx_d;
      bit_cnt_q     <= bit_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      spi_tx_byte_q <= spi_tx_byte_d;
      pkt_ld_q      <= pkt_ld_d;
      shift_rst_q   <= shift_rst_d;
      irq_q         <= irq_d;
      tx_bit_q      <= tx_bit_d;
      tx_active_q   <= tx_active_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       state_d = rx_mode ? S_RX_WAIT : S_TX_COLLECT;
      S_RX_WAIT: begin
        if (!rx_mode)        state_d = S_IDLE;
        else if (pkt_rise_c) state_d = S_RX_READ;
      end
      S_RX_READ: begin
        if (cs_rise_c && last_byte_c) state_d = S_RX_WAIT;
        else if (tmo_hit_c)           state_d = S_RX_WAIT;
      end
      S_TX_COLLECT: begin
        if (cs_rise_c && last_byte_c)                             state_d = S_TX_SEND;
        else if (!cs_rise_c && rx_mode && (byte_idx_q == '0))     state_d = S_IDLE;
      end
      S_TX_SEND: begin
        if (sh_en && last_bit_c) state_d = S_IDLE;
      end
      default:      state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    pkt_d         = pkt_q;
    tx_d          = tx_q;
    byte_idx_d    = byte_idx_q;
    bit_cnt_d     = bit_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    pkt_ld_d      = 1'b0;
    shift_rst_d   = 1'b0;
    irq_d         = irq_q;
    overrun_d     = 1'b0;
    timeout_d     = 1'b0;
    spi_tx_byte_d = '0;
    tx_sel_c      = '0;
    case (state_q)
      S_RX_WAIT: begin
        if (rx_mode && pkt_rise_c) begin
          pkt_d      = shift_data;
          pkt_ld_d   = 1'b1;
          byte_idx_d = '0;
          irq_d      = 1'b1;
          tmo_cnt_d  = '0;
        end
      end
      S_RX_READ: begin
        if (cs_edge_c)       tmo_cnt_d = '0;
        else if (!tmo_hit_c) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        if (cs_rise_c) begin
          if (last_byte_c) begin
            shift_rst_d = 1'b1;
            irq_d       = 1'b0;
            byte_idx_d  = '0;
          end else begin
            byte_idx_d  = byte_idx_q + IDX_W'(1);
          end
        end else if (tmo_hit_c) begin
          timeout_d   = 1'b1;
          shift_rst_d = 1'b1;
          irq_d       = 1'b0;
          byte_idx_d  = '0;
          tmo_cnt_d   = '0;
        end
        // A new packet during readout is dropped; pkt_q keeps the old one.
        if (pkt_rise_c) overrun_d = 1'b1;
      end
      S_TX_COLLECT: begin
        if (cs_rise_c) begin
          for (int i = 0; i < PKT_BYTES; i++) begin
            if (byte_idx_q == IDX_W'(i)) tx_d[PKT_W-8-8*i +: 8] = spi_rx_byte;
          end
          if (last_byte_c) begin
            byte_idx_d = '0;
            bit_cnt_d  = '0;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end
      end
      S_TX_SEND: begin
        if (sh_en) bit_cnt_d = last_bit_c ? '0 : bit_cnt_q + BIT_W'(1);
        if (cs_fall_c) overrun_d = 1'b1;
      end
      default: ;
    endcase

    // Registered outputs track the upcoming state so they align with it.
    if (state_d == S_RX_READ) begin
      for (int i = 0; i < PKT_BYTES; i++) begin
        if (byte_idx_d == IDX_W'(i)) spi_tx_byte_d = pkt_d[PKT_W-8-8*i +: 8];
      end
    end
    tx_active_d = (state_d == S_TX_SEND);
    tx_sel_c    = BIT_W'(PKT_W - 1) - bit_cnt_d;
    tx_bit_d    = tx_active_d & tx_d[tx_sel_c];
  end

  assign spi_tx_byte = spi_tx_byte_q;
  assign pkt_ld      = pkt_ld_q;
  assign shift_rst   = shift_rst_q;
  assign irq         = irq_q;
  assign tx_bit      = tx_bit_q;
  assign tx_active   = tx_active_q;
  assign byte_idx    = byte_idx_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_link_pkt_sched.sv
// Directed bench for link_pkt_sched: RX readout, overrun, timeout, TX
// serialization and mid-operation reset, checked through expectation queues.
module tb_link_pkt_sched;

  logic        clk = 1'b0;
  logic        rst_n, rx_mode, pkt_rec, cs, sh_en;
  logic [63:0] shift_data;
  logic [7:0]  spi_rx_byte, spi_tx_byte;
  logic        pkt_ld, shift_rst, irq, tx_bit, tx_active, overrun, timeout;
  logic [2:0]  byte_idx;

  int n_vec = 0, n_err = 0;
  int n_pkt_ld = 0, n_shrst = 0, n_ovr = 0, n_tmo = 0;
  logic rx_chk = 1'b0, tx_chk = 1'b0;
  logic [7:0] exp_bytes[$];
  logic       exp_bits[$];

  link_pkt_sched #(.PKT_BYTES(8), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_mode(rx_mode), .pkt_rec(pkt_rec),
    .shift_data(shift_data), .cs(cs), .spi_rx_byte(spi_rx_byte), .sh_en(sh_en),
    .spi_tx_byte(spi_tx_byte), .pkt_ld(pkt_ld), .shift_rst(shift_rst), .irq(irq),
    .tx_bit(tx_bit), .tx_active(tx_active), .byte_idx(byte_idx),
    .overrun(overrun), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [7:0] b, input int gap);
    spi_rx_byte = b;
    cs = 1'b0;
    repeat (4) tick();
    cs = 1'b1;
    repeat (gap) tick();
  endtask

  task automatic send_pkt(input logic [63:0] d);
    shift_data = d;
    pkt_rec = 1'b1;
    repeat (2) tick();
    pkt_rec = 1'b0;
    tick();
  endtask

  task automatic push_bytes(input logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) exp_bytes.push_back(d[63-8*i -: 8]);
  endtask

  task automatic strobe();
    sh_en = 1'b1;
    tick();
    sh_en = 1'b0;
    tick();
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {46'd0, spi_tx_byte, pkt_ld, shift_rst, irq, tx_bit, tx_active,
               byte_idx, overrun, timeout}, 64'd0);
  endtask

  // Monitor: pulse counters, SPI byte at each frame start, TX bit at each strobe.
  initial begin
    logic cs_prev;
    cs_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (pkt_ld)    n_pkt_ld++;
      if (shift_rst) n_shrst++;
      if (overrun)   n_ovr++;
      if (timeout)   n_tmo++;
      if (rx_chk && cs_prev && !cs) begin
        if (exp_bytes.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rx_byte: got %0h, expected nothing queued", spi_tx_byte);
        end else chk("rx_byte", 64'(spi_tx_byte), 64'(exp_bytes.pop_front()));
      end
      if (tx_chk && sh_en) begin
        if (exp_bits.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL tx_bit: got %0b, expected nothing queued", tx_bit);
        end else chk("tx_bit", 64'(tx_bit), 64'(exp_bits.pop_front()));
      end
      cs_prev = cs;
    end
  end

  initial begin
    logic [63:0] w;
    int  n;
    logic found;
    rst_n = 1'b0; rx_mode = 1'b1; pkt_rec = 1'b0; shift_data = '0;
    cs = 1'b1; spi_rx_byte = '0; sh_en = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk_all_zero("reset_outputs");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // RX readout of one packet
    rx_chk = 1'b1;
    push_bytes(64'h0123456789ABCDEF, 8);
    send_pkt(64'h0123456789ABCDEF);
    repeat (3) tick();
    chk("rx_pkt_ld_count", 64'(n_pkt_ld), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk("rx_irq_hold", 64'(irq), 64'd1);
      frame(8'h00, 5);
    end
    tick();
    chk("rx_shift_rst_count", 64'(n_shrst), 64'd1);
    chk("rx_irq_clear", 64'(irq), 64'd0);
    chk("rx_byte_idx_clear", 64'(byte_idx), 64'd0);

    // Overrun: second packet mid-readout is dropped
    push_bytes(64'h1122334455667788, 8);
    send_pkt(64'h1122334455667788);
    repeat (3) tick();
    for (int i = 0; i < 3; i++) frame(8'h00, 5);
    send_pkt(64'hDEADBEEFCAFEF00D);
    repeat (3) tick();
    chk("ovr_count", 64'(n_ovr), 64'd1);
    chk("ovr_pkt_ld_count", 64'(n_pkt_ld), 64'd2);
    for (int i = 0; i < 5; i++) frame(8'h00, 5);
    tick();
    chk("ovr_shift_rst_count", 64'(n_shrst), 64'd2);

    // Timeout after three frames
    push_bytes(64'hA1B2C3D4E5F60718, 3);
    send_pkt(64'hA1B2C3D4E5F60718);
    repeat (3) tick();
    frame(8'h00, 5);
    frame(8'h00, 5);
    frame(8'h00, 0);
    n = 0; found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      n++;
      if (timeout) found = 1'b1;
    end
    chk("tmo_seen", 64'(found), 64'd1);
    chk("tmo_latency_100_to_106", 64'(n >= 100 && n <= 106), 64'd1);
    chk("tmo_shift_rst", 64'(shift_rst), 64'd1);
    tick();
    chk("tmo_irq", 64'(irq), 64'd0);
    chk("tmo_byte_idx", 64'(byte_idx), 64'd0);
    chk("tmo_count", 64'(n_tmo), 64'd1);

    // TX collect and serialize, with a stray frame during send
    rx_chk = 1'b0;
    rx_mode = 1'b0;
    repeat (4) tick();
    w = 64'hA500FF5AC3817E3C;
    for (int i = 0; i < 64; i++) exp_bits.push_back(w[63-i]);
    for (int i = 0; i < 8; i++) frame(w[63-8*i -: 8], 5);
    repeat (2) tick();
    chk("tx_active_set", 64'(tx_active), 64'd1);
    tx_chk = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (i == 10) begin
        cs = 1'b0;
        repeat (3) tick();
        cs = 1'b1;
        repeat (4) tick();
      end
      strobe();
    end
    tick();
    chk("tx_active_clear", 64'(tx_active), 64'd0);
    chk("tx_bit_clear", 64'(tx_bit), 64'd0);
    chk("tx_ovr_count", 64'(n_ovr), 64'd2);

    // Reset during RX readout at byte 4, then a fresh packet from byte 0
    rx_mode = 1'b1;
    repeat (4) tick();
    rx_chk = 1'b1;
    push_bytes(64'h0F1E2D3C4B5A6978, 4);
    send_pkt(64'h0F1E2D3C4B5A6978);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) frame(8'h00, 5);
    chk("rx_mid_byte_idx", 64'(byte_idx), 64'd4);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("rx_mid_reset_outputs");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    push_bytes(64'h8899AABBCCDDEEFF, 8);
    send_pkt(64'h8899AABBCCDDEEFF);
    repeat (3) tick();
    for (int i = 0; i < 8; i++) frame(8'h00, 5);
    tick();
    chk("rx_fresh_irq_clear", 64'(irq), 64'd0);

    // Reset during TX send at bit 20
    rx_chk = 1'b0;
    tx_chk = 1'b0;
    rx_mode = 1'b0;
    repeat (4) tick();
    w = 64'hC0FFEE0123456789;
    for (int i = 0; i < 20; i++) exp_bits.push_back(w[63-i]);
    for (int i = 0; i < 8; i++) frame(w[63-8*i -: 8], 5);
    repeat (2) tick();
    tx_chk = 1'b1;
    for (int i = 0; i < 20; i++) strobe();
    chk("tx_mid_active", 64'(tx_active), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("tx_mid_reset_outputs");
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    chk("bytes_drained", 64'(exp_bytes.size()), 64'd0);
    chk("bits_drained", 64'(exp_bits.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
